fifo_wr_scheduler: RTL and testbench
====================================

Name: fifo_wr_scheduler

Overview:
Write-side scheduler for the TX FIFO memory. Shares the single FIFO write port between two requesters: the ALU result, which is 2*DATA_WIDTH wide and is sent as two bytes, and the register-file read data, which is one byte. Arbitration is round-robin. The block sequences multi-byte writes and stalls on wfull, so it never issues a write into a full FIFO. It sits in the write clock domain, directly in front of the FIFO memory and write-pointer logic.

Parameters:
DATA_WIDTH, 8, FIFO word width; RF payload width; ALU payload is 2*DATA_WIDTH.

Ports:
wclk  input  1  write-domain clock.
wrst_n  input  1  asynchronous active-low reset.
alu_valid  input  1  ALU requester has a result; held until alu_ack.
alu_data  input  2*DATA_WIDTH  ALU result; stable while alu_valid=1.
alu_ack  output  1  1-cycle accept pulse to ALU requester.
rf_valid  input  1  RF requester has data; held until rf_ack.
rf_data  input  DATA_WIDTH  RF read data; stable while rf_valid=1.
rf_ack  output  1  1-cycle accept pulse to RF requester.
wfull  input  1  FIFO full flag (synchronised, write domain).
winc  output  1  FIFO write strobe.
wdata  output  DATA_WIDTH  FIFO write data.
busy  output  1  high while a transaction is being written.

Behaviour:
- Clock and reset: one clock, wclk; asynchronous active-low reset, wrst_n.
- Reset values: state=IDLE, alu_ack=0, rf_ack=0, winc=0, wdata=0, busy=0, hold register=0, src flag=0, last_grant=RF (so the ALU wins the first tie).
- Reset asserted mid-transaction: the transaction is dropped immediately, no partial bytes are completed, and all outputs take their reset values.
- State machine: IDLE, WR_LO, WR_HI.
- IDLE:
  - Only one valid asserted: grant that source.
  - Both valid asserted: grant the source not in last_grant.
  - Grant cycle: the matching ack is high for this cycle only (combinational from valid and state). At the edge the block latches the payload into the hold register, records the source, updates last_grant, and moves to WR_LO.
  - No valid asserted: stay in IDLE; both acks stay 0.
- ALU payload: hold = alu_data.
- RF payload: hold[DATA_WIDTH-1:0] = rf_data; upper half is zero.
- WR_LO:
  - wdata = hold[DATA_WIDTH-1:0].
  - winc = ~wfull (combinational).
  - If wfull=0: a write occurs this cycle. Next state is WR_HI if the source is ALU, otherwise IDLE.
  - If wfull=1: stay in WR_LO; wdata is held stable.
- WR_HI:
  - wdata = hold[2*DATA_WIDTH-1:DATA_WIDTH].
  - winc = ~wfull.
  - On a write, go to IDLE; otherwise stay in WR_HI.
- winc is never high in IDLE. winc is never high while wfull=1.
- wdata is 0 in IDLE.
- Byte order: LSB first, then MSB.
- busy = (state != IDLE).
- Acks are never asserted outside IDLE. A requester that raises valid during a transaction waits for the return to IDLE.
- Throughput with no stalls:
  - ALU transaction: 3 cycles (grant, LO, HI).
  - RF transaction: 2 cycles (grant, LO).
- Back-to-back: a new grant may occur in the IDLE cycle immediately after the last byte is written.
- wfull toggling during WR_LO or WR_HI: only the wfull value in the current cycle matters. No bytes are duplicated or skipped.

Test Plan:
- Reset, then alu_valid=1 with alu_data=16'hA55A and wfull=0: alu_ack high in cycle 0. winc high in cycles 1 and 2 with wdata 8'h5A then 8'hA5. busy=1 in cycles 1-2. State is IDLE in cycle 3.
- rf_valid=1 with rf_data=8'h3C: rf_ack high in cycle 0. Exactly one write of 8'h3C in cycle 1; winc=0 afterwards.
- alu_valid and rf_valid both held high, ALU=16'h1234, RF=8'h77, repeated: grants follow ALU, RF, ALU, RF. Write stream is 34,12,77,34,12,77. No ack overlaps.
- ALU transfer of 16'hBEEF with wfull=1 during WR_LO for 4 cycles: winc=0 and wdata=8'hEF held. After wfull falls, writes are EF then BE. Exactly 2 winc pulses in total.
- wfull=1 raised only in WR_HI for 2 cycles: LSB written once, then MSB written once after release. Total winc count = 2.
- wrst_n pulsed low during WR_HI of an ALU transfer: winc, wdata and busy go to 0 asynchronously. After release, with both requesters valid, the ALU is granted first.

Source files
------------

// File: rtl/fifo_wr_scheduler.sv
// fifo_wr_scheduler
// Write-side scheduler for the TX FIFO memory. Two requesters share the
// single FIFO write port: the ALU (2*DATA_WIDTH result, written as two bytes,
// LSB first) and the register file (one DATA_WIDTH byte). Arbitration is
// round-robin. The block never strobes winc while wfull is high.
//
// Handshake: a requester raises *_valid with stable data and holds both until
// it sees *_ack. The ack is a one-cycle pulse, asserted only in IDLE in the
// cycle the source is granted; the payload is captured on that clock edge.
//
// Ports:
//   wclk, wrst_n        write-domain clock, asynchronous active-low reset
//   alu_valid/alu_data  ALU request and 2*DATA_WIDTH payload
//   alu_ack             one-cycle accept pulse to the ALU
//   rf_valid/rf_data    RF request and DATA_WIDTH payload
//   rf_ack              one-cycle accept pulse to the RF
//   wfull               FIFO full flag (already in the write domain)
//   winc, wdata         FIFO write strobe and write data
//   busy                high while a transaction is being written
//   dbg_state           current FSM state (0=IDLE, 1=WR_LO, 2=WR_HI)
module fifo_wr_scheduler #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic                    alu_valid,
    input  logic [2*DATA_WIDTH-1:0] alu_data,
    output logic                    alu_ack,
    input  logic                    rf_valid,
    input  logic [DATA_WIDTH-1:0]   rf_data,
    output logic                    rf_ack,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
    logic                    src_alu_q, src_alu_d;   // 1: current payload is from the ALU
    logic                    last_alu_q, last_alu_d; // 1: ALU had the most recent grant
    logic                    grant_alu, grant_rf;

    // Round-robin: on a tie, the source that did not win last time goes.
    // last_alu resets to 0 (RF), so the ALU wins the first tie.
    assign grant_alu = alu_valid & (~rf_valid | ~last_alu_q);
    assign grant_rf  = rf_valid & ~grant_alu;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            src_alu_q  <= 1'b0;
            last_alu_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            src_alu_q  <= src_alu_d;
            last_alu_q <= last_alu_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        src_alu_d  = src_alu_q;
        last_alu_d = last_alu_q;
        alu_ack    = 1'b0;
        rf_ack     = 1'b0;
        winc       = 1'b0;
        wdata      = '0;
        case (state_q)
            IDLE: begin
                // Acks are gated by reset so nothing is accepted while the
                // block is held in reset.
                if (grant_alu) begin
                    alu_ack    = wrst_n;
                    hold_d     = alu_data;
                    src_alu_d  = 1'b1;
                    last_alu_d = 1'b1;
                    state_d    = WR_LO;
                end else if (grant_rf) begin
                    rf_ack     = wrst_n;
                    hold_d     = {{DATA_WIDTH{1'b0}}, rf_data};
                    src_alu_d  = 1'b0;
                    last_alu_d = 1'b0;
                    state_d    = WR_LO;
                end
            end
            WR_LO: begin
                wdata = hold_q[DATA_WIDTH-1:0];
                winc  = ~wfull;
                if (!wfull) begin
                    state_d = src_alu_q ? WR_HI : IDLE;
                end
            end
            WR_HI: begin
                wdata = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
                winc  = ~wfull;
                if (!wfull) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_wr_scheduler.sv
// Bench for fifo_wr_scheduler: directed scenarios followed by random traffic.
// A reference model works at transaction level (who gets granted, which bytes
// must appear, how many writes remain) and a monitor compares the DUT against
// it on every falling edge.
module tb_fifo_wr_scheduler;

    localparam int DW = 8;

    logic          wclk;
    logic          wrst_n;
    logic          alu_valid;
    logic [2*DW-1:0] alu_data;
    logic          alu_ack;
    logic          rf_valid;
    logic [DW-1:0] rf_data;
    logic          rf_ack;
    logic          wfull;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          busy;
    logic [1:0]    dbg_state;

    int tests = 0;
    int fails = 0;
    int winc_cnt = 0;

    // Handshake flags from the monitor to the drivers.
    bit alu_acked = 0;
    bit rf_acked  = 0;

    // Reference model state.
    logic [DW-1:0] exp_q[$];
    int  m_rem      = 0;   // bytes still to write for the granted transaction
    bit  m_last_alu = 0;   // last grant went to the ALU
    bit  e_alu_ack  = 0;
    bit  e_rf_ack   = 0;
    bit  e_busy     = 0;
    bit  e_winc     = 0;

    fifo_wr_scheduler #(.DATA_WIDTH(DW)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .alu_valid (alu_valid),
        .alu_data  (alu_data),
        .alu_ack   (alu_ack),
        .rf_valid  (rf_valid),
        .rf_data   (rf_data),
        .rf_ack    (rf_ack),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Evaluated on the falling edge with the inputs of the current cycle.
    always @(negedge wclk) begin
        if (!wrst_n) begin
            m_rem      = 0;
            m_last_alu = 0;
            exp_q.delete();
            e_alu_ack  = 0;
            e_rf_ack   = 0;
            e_busy     = 0;
            e_winc     = 0;
        end else if (m_rem == 0) begin
            e_busy    = 0;
            e_winc    = 0;
            e_alu_ack = alu_valid && (!rf_valid || !m_last_alu);
            e_rf_ack  = rf_valid && !e_alu_ack;
            if (e_alu_ack) begin
                exp_q.push_back(alu_data[DW-1:0]);
                exp_q.push_back(alu_data[2*DW-1:DW]);
                m_rem      = 2;
                m_last_alu = 1;
            end else if (e_rf_ack) begin
                exp_q.push_back(rf_data);
                m_rem      = 1;
                m_last_alu = 0;
            end
        end else begin
            e_alu_ack = 0;
            e_rf_ack  = 0;
            e_busy    = 1;
            e_winc    = !wfull;
            if (!wfull) m_rem--;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge wclk) begin
        #1;
        chk("alu_ack", alu_ack, e_alu_ack);
        chk("rf_ack", rf_ack, e_rf_ack);
        chk("busy", busy, e_busy);
        chk("winc", winc, e_winc);
        if (winc) winc_cnt++;
        if (alu_ack) alu_acked = 1;
        if (rf_ack)  rf_acked  = 1;
        if (e_busy) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_underflow", 32'd0, 32'd1);
            end else begin
                chk("wdata", wdata, exp_q[0]);
                if (e_winc) void'(exp_q.pop_front());
            end
        end else begin
            chk("wdata_idle", wdata, '0);
        end
    end

    // ---------------- drivers ----------------
    // One cycle of stimulus: retire acknowledged requests, optionally raise
    // new ones (fixed or random payload) and set wfull.
    task automatic tick(input bit full, input int p_alu, input int p_rf,
                        input logic [2*DW-1:0] a, input logic [DW-1:0] r, input bit rnd);
        @(posedge wclk);
        #1;
        if (alu_acked) begin alu_valid = 0; alu_acked = 0; end
        if (rf_acked)  begin rf_valid  = 0; rf_acked  = 0; end
        if (!alu_valid && $urandom_range(0, 99) < p_alu) begin
            alu_valid = 1;
            alu_data  = rnd ? (2*DW)'($urandom) : a;
        end
        if (!rf_valid && $urandom_range(0, 99) < p_rf) begin
            rf_valid = 1;
            rf_data  = rnd ? DW'($urandom) : r;
        end
        wfull = full;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, '0, '0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        wrst_n    = 0;
        alu_valid = 0;
        alu_data  = '0;
        rf_valid  = 0;
        rf_data   = '0;
        wfull     = 0;
        repeat (3) @(posedge wclk);
        #1;
        wrst_n = 1;
        settle(2);

        // ALU single transfer, no stalls.
        tick(0, 100, 0, 16'hA55A, '0, 0);
        settle(4);

        // RF single transfer.
        tick(0, 0, 100, '0, 8'h3C, 0);
        settle(4);

        // Both requesters held: strict alternation ALU, RF, ALU, RF.
        for (int i = 0; i < 12; i++) tick(0, 100, 100, 16'h1234, 8'h77, 0);
        settle(8);

        // Stall in WR_LO for 4 cycles.
        c0 = winc_cnt;
        tick(1, 100, 0, 16'hBEEF, '0, 0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, '0, '0, 0);
        settle(4);
        chk("winc_count_lo_stall", winc_cnt - c0, 2);

        // Stall only in WR_HI for 2 cycles.
        c0 = winc_cnt;
        tick(0, 100, 0, 16'hC0DE, '0, 0);
        tick(0, 0, 0, '0, '0, 0);
        tick(1, 0, 0, '0, '0, 0);
        tick(1, 0, 0, '0, '0, 0);
        settle(4);
        chk("winc_count_hi_stall", winc_cnt - c0, 2);

        // Reset in the middle of WR_HI, then a tie must go to the ALU.
        tick(0, 100, 0, 16'h5AA5, '0, 0);
        tick(0, 0, 0, '0, '0, 0);
        tick(0, 0, 0, '0, '0, 0);  // this cycle is WR_HI
        #3;
        wrst_n = 0;
        #1;
        chk("rst_async_winc", winc, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_wdata", wdata, 0);
        @(posedge wclk);
        #1;
        alu_valid = 1;
        alu_data  = 16'h0F0F;
        rf_valid  = 1;
        rf_data   = 8'h99;
        alu_acked = 0;
        rf_acked  = 0;
        @(posedge wclk);
        #1;
        wrst_n = 1;
        for (int i = 0; i < 6; i++) tick(0, 0, 0, '0, '0, 0);
        settle(6);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 99) < 30, 45, 45, '0, '0, 1);
        end
        settle(12);
        @(negedge wclk);
        #2;
        chk("exp_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
